clock_hms: RTL and testbench

CLOCK_HMS -- requirements
Module: clock_hms

---
 rtl/clock_hms.sv | 146 ++++++++++++++
 tb/tb_clock_hms.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_hms.sv
// clock_hms: hours/minutes/seconds time-of-day counter held in packed BCD.
// A small FSM selects between stopped, running and two set modes (hours, minutes).
//
// Ports:
//   iClk        system clock, all state changes on the rising edge
//   iRst        synchronous active-high reset
//   iTick       one-cycle 1 Hz pulse, advances time by one second while running
//   iStartStop  one-cycle pulse, toggles between stopped and running
//   iMode       one-cycle pulse, steps STOP -> SET_HR -> SET_MIN -> STOP
//   iInc        one-cycle pulse, increments the field selected by the set mode
//   oSec        seconds, packed BCD 00..59
//   oMin        minutes, packed BCD 00..59
//   oHr         hours, packed BCD 00..HR_LIM-1
//   oState      current FSM state register
//   oRollover   one-cycle pulse when a tick wraps the full day to 00:00:00
module clock_hms #(
    parameter int unsigned HR_LIM = 24
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick,
    input  logic       iStartStop,
    input  logic       iMode,
    input  logic       iInc,
    output logic [7:0] oSec,
    output logic [7:0] oMin,
    output logic [7:0] oHr,
    output logic [1:0] oState,
    output logic       oRollover
);

    localparam logic [1:0] StStop   = 2'b00;
    localparam logic [1:0] StRun    = 2'b01;
    localparam logic [1:0] StSetHr  = 2'b10;
    localparam logic [1:0] StSetMin = 2'b11;

    // Last legal hour (HR_LIM-1) expressed in packed BCD.
    localparam logic [3:0] HrMaxTens  = 4'((HR_LIM - 1) / 10);
    localparam logic [3:0] HrMaxUnits = 4'((HR_LIM - 1) % 10);
    localparam logic [7:0] HrMax      = {HrMaxTens, HrMaxUnits};

    logic [1:0] state_q, state_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hr_q, hr_d;
    logic       roll_q, roll_d;

    // BCD increment for a 00..59 field, wrapping 59 -> 00.
    function automatic logic [7:0] inc_60(input logic [7:0] v);
        if (v == 8'h59) begin
            inc_60 = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            inc_60 = {v[7:4] + 4'd1, 4'd0};
        end else begin
            inc_60 = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // BCD increment for the hour field, wrapping HR_LIM-1 -> 00.
    function automatic logic [7:0] inc_hr(input logic [7:0] v);
        if (v == HrMax) begin
            inc_hr = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            inc_hr = {v[7:4] + 4'd1, 4'd0};
        end else begin
            inc_hr = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        roll_d  = 1'b0;
        case (state_q)
            StStop: begin
                // Start/stop wins over mode when both arrive together.
                if (iStartStop) begin
                    state_d = StRun;
                end else if (iMode) begin
                    state_d = StSetHr;
                end
            end
            StRun: begin
                // The tick is still applied on the edge that stops the clock.
                if (iTick) begin
                    sec_d = inc_60(sec_q);
                    if (sec_q == 8'h59) begin
                        min_d = inc_60(min_q);
                        if (min_q == 8'h59) begin
                            hr_d = inc_hr(hr_q);
                            if (hr_q == HrMax) begin
                                roll_d = 1'b1;
                            end
                        end
                    end
                end
                if (iStartStop) begin
                    state_d = StStop;
                end
            end
            StSetHr: begin
                if (iInc) begin
                    hr_d = inc_hr(hr_q);
                end
                if (iMode) begin
                    state_d = StSetMin;
                end
            end
            default: begin // StSetMin
                if (iInc) begin
                    min_d = inc_60(min_q);
                end
                // Leaving set mode starts the new time from a clean second.
                if (iMode) begin
                    state_d = StStop;
                    sec_d   = 8'h00;
                end
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StStop;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hr_q    <= 8'h00;
            roll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            roll_q  <= roll_d;
        end
    end

    assign oSec      = sec_q;
    assign oMin      = min_q;
    assign oHr       = hr_q;
    assign oState    = state_q;
    assign oRollover = roll_q;

endmodule

// File: tb/tb_clock_hms.sv
// Bench for clock_hms: drives a 24-hour and a 12-hour instance with shared stimulus.
// Expected outputs come from a fixed vector table and from an integer-arithmetic
// reference model, queued when stimulus is driven and compared after the edge.
module tb_clock_hms;

    typedef struct {
        logic [1:0] st;
        logic [7:0] sec;
        logic [7:0] min;
        logic [7:0] hr;
        logic       roll;
    } exp_t;

    typedef struct {
        bit         r, t, s, m, i;
        logic [1:0] st;
        logic [7:0] sec, min, hr;
        logic       roll;
    } vec_t;

    logic clk = 1'b0;
    logic rst, tick, ss, mode, inc;

    logic [7:0] sec24, min24, hr24, sec12, min12, hr12;
    logic [1:0] st24, st12;
    logic       roll24, roll12;

    int checks = 0;
    int errors = 0;

    exp_t q24[$];
    exp_t q12[$];

    // Reference model state, index 0 = 24-hour, 1 = 12-hour.
    int m_st[2], m_h[2], m_m[2], m_s[2];
    bit m_roll[2];
    int lim[2] = '{24, 12};

    vec_t vecs[15];

    always #20 clk = ~clk;

    clock_hms #(.HR_LIM(24)) dut24 (
        .iClk(clk), .iRst(rst), .iTick(tick), .iStartStop(ss), .iMode(mode), .iInc(inc),
        .oSec(sec24), .oMin(min24), .oHr(hr24), .oState(st24), .oRollover(roll24)
    );

    clock_hms #(.HR_LIM(12)) dut12 (
        .iClk(clk), .iRst(rst), .iTick(tick), .iStartStop(ss), .iMode(mode), .iInc(inc),
        .oSec(sec12), .oMin(min12), .oHr(hr12), .oState(st12), .oRollover(roll12)
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic model_step(input bit r, input bit t, input bit s, input bit m,
                              input bit i);
        for (int k = 0; k < 2; k++) begin
            m_roll[k] = 1'b0;
            if (r) begin
                m_st[k] = 0; m_h[k] = 0; m_m[k] = 0; m_s[k] = 0;
            end else begin
                case (m_st[k])
                    0: if (s) m_st[k] = 1; else if (m) m_st[k] = 2;
                    1: begin
                        if (t) begin
                            m_s[k]++;
                            if (m_s[k] == 60) begin
                                m_s[k] = 0; m_m[k]++;
                                if (m_m[k] == 60) begin
                                    m_m[k] = 0; m_h[k]++;
                                    if (m_h[k] == lim[k]) begin
                                        m_h[k] = 0; m_roll[k] = 1'b1;
                                    end
                                end
                            end
                        end
                        if (s) m_st[k] = 0;
                    end
                    2: begin
                        if (i) m_h[k] = (m_h[k] + 1) % lim[k];
                        if (m) m_st[k] = 3;
                    end
                    default: begin
                        if (i) m_m[k] = (m_m[k] + 1) % 60;
                        if (m) begin m_st[k] = 0; m_s[k] = 0; end
                    end
                endcase
            end
        end
    endtask

    function automatic exp_t model_exp(input int k);
        exp_t e;
        e.st   = 2'(m_st[k]);
        e.sec  = to_bcd(m_s[k]);
        e.min  = to_bcd(m_m[k]);
        e.hr   = to_bcd(m_h[k]);
        e.roll = m_roll[k];
        return e;
    endfunction

    task automatic cmp(input string lbl, input string fld, input int d, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s hr%0d %s: got %h expected %h", lbl, d, fld, got, want);
        end
    endtask

    // Apply one cycle of stimulus, then compare both instances against queued results.
    task automatic cycle(input string lbl, input bit r, input bit t, input bit s, input bit m,
                         input bit i);
        exp_t e;
        rst = r; tick = t; ss = s; mode = m; inc = i;
        @(posedge clk);
        #1;
        rst = 0; tick = 0; ss = 0; mode = 0; inc = 0;
        e = q24.pop_front();
        cmp(lbl, "state", 24, {6'd0, st24}, {6'd0, e.st});
        cmp(lbl, "sec", 24, sec24, e.sec);
        cmp(lbl, "min", 24, min24, e.min);
        cmp(lbl, "hr", 24, hr24, e.hr);
        cmp(lbl, "roll", 24, {7'd0, roll24}, {7'd0, e.roll});
        e = q12.pop_front();
        cmp(lbl, "state", 12, {6'd0, st12}, {6'd0, e.st});
        cmp(lbl, "sec", 12, sec12, e.sec);
        cmp(lbl, "min", 12, min12, e.min);
        cmp(lbl, "hr", 12, hr12, e.hr);
        cmp(lbl, "roll", 12, {7'd0, roll12}, {7'd0, e.roll});
    endtask

    task automatic step(input string lbl, input bit r, input bit t, input bit s, input bit m,
                        input bit i);
        model_step(r, t, s, m, i);
        q24.push_back(model_exp(0));
        q12.push_back(model_exp(1));
        cycle(lbl, r, t, s, m, i);
    endtask

    task automatic set_vec(input int n, input bit r, input bit t, input bit s, input bit m,
                           input bit i, input logic [1:0] st, input logic [7:0] sec,
                           input logic [7:0] mn, input logic [7:0] hr, input logic roll);
        vecs[n].r = r; vecs[n].t = t; vecs[n].s = s; vecs[n].m = m; vecs[n].i = i;
        vecs[n].st = st; vecs[n].sec = sec; vecs[n].min = mn; vecs[n].hr = hr;
        vecs[n].roll = roll;
    endtask

    initial begin
        exp_t e;
        rst = 0; tick = 0; ss = 0; mode = 0; inc = 0;

        //           r  t  s  m  i   st     sec    min    hr     roll
        set_vec(0,  1, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0);
        set_vec(1,  0, 0, 1, 0, 0, 2'b01, 8'h00, 8'h00, 8'h00, 0);
        set_vec(2,  0, 1, 0, 0, 0, 2'b01, 8'h01, 8'h00, 8'h00, 0);
        set_vec(3,  0, 1, 1, 0, 0, 2'b00, 8'h02, 8'h00, 8'h00, 0);
        set_vec(4,  0, 1, 0, 0, 0, 2'b00, 8'h02, 8'h00, 8'h00, 0);
        set_vec(5,  0, 0, 0, 1, 0, 2'b10, 8'h02, 8'h00, 8'h00, 0);
        set_vec(6,  0, 0, 0, 0, 1, 2'b10, 8'h02, 8'h00, 8'h01, 0);
        set_vec(7,  0, 1, 0, 0, 0, 2'b10, 8'h02, 8'h00, 8'h01, 0);
        set_vec(8,  0, 0, 0, 1, 1, 2'b11, 8'h02, 8'h00, 8'h02, 0);
        set_vec(9,  0, 0, 0, 0, 1, 2'b11, 8'h02, 8'h01, 8'h02, 0);
        set_vec(10, 0, 1, 1, 0, 0, 2'b11, 8'h02, 8'h01, 8'h02, 0);
        set_vec(11, 0, 0, 0, 1, 0, 2'b00, 8'h00, 8'h01, 8'h02, 0);
        set_vec(12, 0, 0, 0, 0, 1, 2'b00, 8'h00, 8'h01, 8'h02, 0);
        set_vec(13, 0, 0, 1, 1, 0, 2'b01, 8'h00, 8'h01, 8'h02, 0);
        set_vec(14, 1, 1, 0, 0, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0);

        repeat (2) @(posedge clk);
        #1;

        // Fixed vectors: hours stay below 12 so both instances share the expectation.
        for (int n = 0; n < 15; n++) begin
            model_step(vecs[n].r, vecs[n].t, vecs[n].s, vecs[n].m, vecs[n].i);
            e.st = vecs[n].st; e.sec = vecs[n].sec; e.min = vecs[n].min;
            e.hr = vecs[n].hr; e.roll = vecs[n].roll;
            q24.push_back(e);
            q12.push_back(e);
            cycle($sformatf("vec%0d", n), vecs[n].r, vecs[n].t, vecs[n].s, vecs[n].m,
                  vecs[n].i);
        end

        // 61 ticks from reset: 00:01:01, still running.
        step("run61_rst", 1, 0, 0, 0, 0);
        step("run61_go", 0, 0, 1, 0, 0);
        for (int n = 0; n < 61; n++) step("run61_tick", 0, 1, 0, 0, 0);

        // Tick and stop together at 00:00:09, later ticks ignored.
        step("tickstop_rst", 1, 0, 0, 0, 0);
        step("tickstop_go", 0, 0, 1, 0, 0);
        for (int n = 0; n < 9; n++) step("tickstop_tick", 0, 1, 0, 0, 0);
        step("tickstop_both", 0, 1, 1, 0, 0);
        step("tickstop_ignored", 0, 1, 0, 0, 0);

        // Set mode wraps: 25 hour increments, 61 minute increments, exit clears seconds.
        step("set_rst", 1, 0, 0, 0, 0);
        step("set_hr", 0, 0, 0, 1, 0);
        for (int n = 0; n < 25; n++) step("set_hr_inc", 0, 0, 0, 0, 1);
        for (int n = 0; n < 10; n++) step("set_hr_tick", 0, 1, 0, 0, 0);
        step("set_min", 0, 0, 0, 1, 0);
        for (int n = 0; n < 61; n++) step("set_min_inc", 0, 0, 0, 0, 1);
        step("set_exit", 0, 0, 0, 1, 0);
        step("stop_inc", 0, 0, 0, 0, 1);

        // Day wrap: 23:59:59 (11:59:59 on the 12-hour instance), one tick rolls over.
        step("wrap_rst", 1, 0, 0, 0, 0);
        step("wrap_sethr", 0, 0, 0, 1, 0);
        for (int n = 0; n < 23; n++) step("wrap_hr_inc", 0, 0, 0, 0, 1);
        step("wrap_setmin", 0, 0, 0, 1, 0);
        for (int n = 0; n < 59; n++) step("wrap_min_inc", 0, 0, 0, 0, 1);
        step("wrap_exit", 0, 0, 0, 1, 0);
        step("wrap_go", 0, 0, 1, 0, 0);
        for (int n = 0; n < 59; n++) step("wrap_tick", 0, 1, 0, 0, 0);
        step("wrap_rollover", 0, 1, 0, 0, 0);
        step("wrap_after", 0, 1, 0, 0, 0);
        step("wrap_idle", 0, 0, 0, 0, 0);

        // Reset with a tick pending at 12:34:56 while running.
        step("rst_mid_rst", 1, 0, 0, 0, 0);
        step("rst_mid_sethr", 0, 0, 0, 1, 0);
        for (int n = 0; n < 12; n++) step("rst_mid_hr", 0, 0, 0, 0, 1);
        step("rst_mid_setmin", 0, 0, 0, 1, 0);
        for (int n = 0; n < 34; n++) step("rst_mid_min", 0, 0, 0, 0, 1);
        step("rst_mid_exit", 0, 0, 0, 1, 0);
        step("rst_mid_go", 0, 0, 1, 0, 0);
        for (int n = 0; n < 56; n++) step("rst_mid_tick", 0, 1, 0, 0, 0);
        step("rst_mid_reset", 1, 1, 0, 0, 0);
        step("rst_mid_after", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
